mileage_counter: RTL and testbench
==================================

MILEAGE_COUNTER -- requirements
Module: mileage_counter

Interface
REQ-001 The block SHALL have parameter PULSES_PER_UNIT, default 10, giving wheel pulses per 0.1 km distance unit (range 1..255).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the clk cycles a wheel level must be stable before it is accepted (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: level; a rising edge begins a new trip.
REQ-006 The block SHALL have port stop, input, 1 bit: level; a rising edge ends the current trip.
REQ-007 The block SHALL have port wheel, input, 1 bit: asynchronous wheel-sensor pulse.
REQ-008 The block SHALL have port sec_tick, input, 1 bit: one-clk strobe, once per second.
REQ-009 The block SHALL have port distence, output, 16 bits: trip distance in 0.1 km units, consumed by the fare stage.
REQ-010 The block SHALL have port wait_time, output, 8 bits: seconds stationary during the trip.
REQ-011 The block SHALL have port running, output, 1 bit: high only in state RUN.

Function
REQ-012 wheel SHALL pass through a 2-flop synchronizer; one wheel pulse SHALL count on each accepted 0-to-1 transition of the synchronized level.
REQ-013 start and stop SHALL each be edge-detected internally (registered previous value); only rising edges act.
REQ-014 The FSM SHALL have states IDLE, RUN and HOLD.
REQ-015 IDLE -> RUN on start edge; RUN -> HOLD on stop edge; HOLD -> RUN on start edge; no other transitions except reset.
REQ-016 Every entry to RUN SHALL clear distence, wait_time, the pulse prescaler and the stationary counter in the same cycle.
REQ-017 In RUN, the prescaler SHALL count accepted pulses. On reaching PULSES_PER_UNIT it SHALL wrap to 0, and distence SHALL increment in that same cycle.
REQ-018 distence SHALL saturate at 16'hFFFF, with no wrap to 0.
REQ-019 In RUN, a sec_tick with no accepted pulse in the preceding full second SHALL increment wait_time; wait_time SHALL saturate at 255.
REQ-020 The "no pulse this second" flag SHALL clear on sec_tick and SHALL set on any accepted pulse.
REQ-021 In IDLE and HOLD, pulses and sec_tick SHALL be ignored, and distence/wait_time SHALL hold their values so the fare stage can display the final value.
REQ-022 If start and stop edges occur in the same cycle: in RUN, stop SHALL win (go to HOLD); in IDLE/HOLD, start SHALL win.
REQ-023 A pulse accepted in the same cycle as a stop edge SHALL still be counted.
REQ-024 Outputs SHALL be registered; distence SHALL update 1 clk after the prescaler wrap condition is sampled.

Reset
REQ-025 While rst is low, the block SHALL hold state IDLE, distence = 0, wait_time = 0, running = 0, prescaler = 0, synchronizer/edge flops = 0 and debounce counter = 0.
REQ-026 Reset asserted mid-trip SHALL discard the trip immediately; no partial unit SHALL be retained after release.

Configuration
REQ-027 Macro MILEAGE_DEBOUNCE_EN defined: the synchronized wheel level SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples, and shorter glitches SHALL be dropped.
REQ-028 Macro MILEAGE_DEBOUNCE_EN undefined: the synchronized level SHALL be used directly, and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-029 A shared package taxi_pkg SHALL hold: the state enum (IDLE/RUN/HOLD), the 16-bit distance width, the 8-bit wait-time width, and the saturation constants DIST_MAX and WAIT_MAX.
REQ-030 The debounce filter SHALL be one sub-module, wheel_debounce (sync + filter + edge output), instantiated once.

Verification
REQ-031 Reset, start edge, then 30 wheel pulses at PULSES_PER_UNIT=10 -> distence = 3, running = 1.
REQ-032 In RUN, 9 pulses then stop edge then 5 pulses -> distence = 0, state HOLD; a later start edge -> distence = 0 with a fresh prescaler.
REQ-033 In RUN, 3 sec_ticks with no pulses then 1 tick after a pulse -> wait_time = 3.
REQ-034 Preload near the limit (65535 units reached) plus 20 further pulses -> distence stays 16'hFFFF; 300 idle ticks -> wait_time = 255.
REQ-035 start and stop edges in the same cycle while in RUN -> HOLD; the same in HOLD -> RUN with counters cleared.
REQ-036 With MILEAGE_DEBOUNCE_EN, 2-cycle glitches on wheel -> no count; 6-cycle pulses -> each counted once.

Source files
------------

// File: rtl/taxi_pkg.sv
// Shared types and limits for the taxi meter datapath.
// Trip state, counter widths and saturation values.
package taxi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DIST_W = 16;
    localparam int WAIT_W = 8;

    localparam logic [DIST_W-1:0] DIST_MAX = 16'hFFFF;
    localparam logic [WAIT_W-1:0] WAIT_MAX = 8'hFF;

endpackage

// File: rtl/wheel_debounce.sv
// Wheel sensor front end: 2-flop sync, optional glitch filter, rising-edge pulse.
// Filter present only when MILEAGE_DEBOUNCE_EN is defined.
module wheel_debounce
`ifdef MILEAGE_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic wheel,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= wheel;
            sync2 <= sync1;
        end
    end

`ifdef MILEAGE_DEBOUNCE_EN
    logic [3:0] cnt;

    // A new level is adopted only after DEBOUNCE_CYCLES differing samples in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b0;
            cnt   <= 4'd0;
        end else if (sync2 == level) begin
            cnt <= 4'd0;
        end else if (cnt == 4'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/mileage_counter.sv
// Trip distance and waiting-time counter feeding the fare stage.
// Wheel glitch filter enabled by defining MILEAGE_DEBOUNCE_EN.
module mileage_counter
    import taxi_pkg::*;
#(
    parameter int unsigned PULSES_PER_UNIT = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              wheel,
    input  logic              sec_tick,
    output logic [DIST_W-1:0] distence,
    output logic [WAIT_W-1:0] wait_time,
    output logic              running
);

    if (PULSES_PER_UNIT < 1 || PULSES_PER_UNIT > 255 ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_param
        $error("mileage_counter: parameter out of range");
    end

    state_t     state;
    state_t     state_next;
    logic       pulse;
    logic       start_q;
    logic       stop_q;
    logic       start_edge;
    logic       stop_edge;
    logic       enter_run;
    logic       counting;
    logic       wrap;
    logic       pulse_seen;
    logic [7:0] presc;

`ifdef MILEAGE_DEBOUNCE_EN
    wheel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_wheel (
        .clk  (clk),
        .rst  (rst),
        .wheel(wheel),
        .pulse(pulse)
    );
`else
    wheel_debounce u_wheel (
        .clk  (clk),
        .rst  (rst),
        .wheel(wheel),
        .pulse(pulse)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
        end
    end

    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Simultaneous edges: stop wins while running, start wins otherwise.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_edge) state_next = RUN;
            RUN:     if (stop_edge)  state_next = HOLD;
            HOLD:    if (start_edge) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enter_run = (state_next == RUN) && (state != RUN);
        counting  = (state == RUN);
        wrap      = (presc == 8'(PULSES_PER_UNIT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
        end else begin
            running <= (state_next == RUN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc      <= 8'd0;
            distence   <= '0;
            wait_time  <= '0;
            pulse_seen <= 1'b0;
        end else if (enter_run) begin
            presc      <= 8'd0;
            distence   <= '0;
            wait_time  <= '0;
            pulse_seen <= 1'b0;
        end else if (counting) begin
            if (pulse) begin
                if (wrap) begin
                    presc <= 8'd0;
                    if (distence != DIST_MAX) begin
                        distence <= distence + 1'b1;
                    end
                end else begin
                    presc <= presc + 8'd1;
                end
            end
            // A pulse on the tick cycle still belongs to the second just ending.
            if (sec_tick) begin
                if (!pulse_seen && !pulse && wait_time != WAIT_MAX) begin
                    wait_time <= wait_time + 1'b1;
                end
                pulse_seen <= 1'b0;
            end else if (pulse) begin
                pulse_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mileage_counter.sv
// Directed bench for mileage_counter: vector table plus corner sequences.
// Covers trips, hold, coincident edges, saturation and wheel filtering.
module tb_mileage_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        wheel = 1'b0;
    logic        sec_tick = 1'b0;
    logic [15:0] distence;
    logic [7:0]  wait_time;
    logic        running;

    int n_checks = 0;
    int n_fail = 0;

`ifdef MILEAGE_DEBOUNCE_EN
    localparam int LAT = 4 + 3;
`else
    localparam int LAT = 3;
`endif

    mileage_counter #(
        .PULSES_PER_UNIT(10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .wheel    (wheel),
        .sec_tick (sec_tick),
        .distence (distence),
        .wait_time(wait_time),
        .running  (running)
    );

    always #5 clk = ~clk;

    typedef enum int {
        OP_RESET, OP_START, OP_STOP, OP_BOTH, OP_PULSES, OP_TICKS
    } op_t;

    typedef struct {
        op_t         op;
        int          n;
        logic [15:0] d;
        logic [7:0]  w;
        logic        r;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycles(2);
    endtask

    task automatic edges(input logic s, input logic p);
        @(negedge clk);
        start = s;
        stop  = p;
        cycles(2);
        start = 1'b0;
        stop  = 1'b0;
        cycles(2);
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wheel = 1'b1;
            cycles(hi);
            wheel = 1'b0;
            cycles(lo - 1);
        end
        cycles(12);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sec_tick = 1'b1;
            @(negedge clk);
            sec_tick = 1'b0;
        end
        cycles(2);
    endtask

    task automatic expect3(input string tag, input logic [15:0] d,
                           input logic [7:0] w, input logic r);
        check({tag, " dist"}, 32'(distence), 32'(d));
        check({tag, " wait"}, 32'(wait_time), 32'(w));
        check({tag, " run"}, 32'(running), 32'(r));
    endtask

    initial begin
        vecs[0]  = '{OP_RESET,    0, 16'd0, 8'd0,   1'b0};
        vecs[1]  = '{OP_START,    0, 16'd0, 8'd0,   1'b1};
        vecs[2]  = '{OP_PULSES,  30, 16'd3, 8'd0,   1'b1};
        vecs[3]  = '{OP_TICKS,    1, 16'd3, 8'd0,   1'b1};
        vecs[4]  = '{OP_TICKS,    3, 16'd3, 8'd3,   1'b1};
        vecs[5]  = '{OP_PULSES,   1, 16'd3, 8'd3,   1'b1};
        vecs[6]  = '{OP_TICKS,    1, 16'd3, 8'd3,   1'b1};
        vecs[7]  = '{OP_STOP,     0, 16'd3, 8'd3,   1'b0};
        vecs[8]  = '{OP_PULSES,  15, 16'd3, 8'd3,   1'b0};
        vecs[9]  = '{OP_TICKS,    5, 16'd3, 8'd3,   1'b0};
        vecs[10] = '{OP_START,    0, 16'd0, 8'd0,   1'b1};
        vecs[11] = '{OP_PULSES,   9, 16'd0, 8'd0,   1'b1};
        vecs[12] = '{OP_STOP,     0, 16'd0, 8'd0,   1'b0};
        vecs[13] = '{OP_PULSES,   5, 16'd0, 8'd0,   1'b0};
        vecs[14] = '{OP_START,    0, 16'd0, 8'd0,   1'b1};
        vecs[15] = '{OP_PULSES,   9, 16'd0, 8'd0,   1'b1};
        vecs[16] = '{OP_PULSES,   1, 16'd1, 8'd0,   1'b1};
        vecs[17] = '{OP_BOTH,     0, 16'd1, 8'd0,   1'b0};
        vecs[18] = '{OP_BOTH,     0, 16'd0, 8'd0,   1'b1};
        vecs[19] = '{OP_PULSES,  10, 16'd1, 8'd0,   1'b1};
        vecs[20] = '{OP_TICKS,  300, 16'd1, 8'd255, 1'b1};
        vecs[21] = '{OP_STOP,     0, 16'd1, 8'd255, 1'b0};
        vecs[22] = '{OP_RESET,    0, 16'd0, 8'd0,   1'b0};
        vecs[23] = '{OP_BOTH,     0, 16'd0, 8'd0,   1'b1};

        rst = 1'b0;
        cycles(2);
        expect3("in_reset", 16'd0, 8'd0, 1'b0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RESET:  do_reset();
                OP_START:  edges(1'b1, 1'b0);
                OP_STOP:   edges(1'b0, 1'b1);
                OP_BOTH:   edges(1'b1, 1'b1);
                OP_PULSES: pulses(vecs[i].n, 6, 6);
                OP_TICKS:  ticks(vecs[i].n);
                default:   ;
            endcase
            expect3($sformatf("row%0d", i), vecs[i].d, vecs[i].w, vecs[i].r);
        end

        // Reset mid-trip drops the partial unit.
        do_reset();
        edges(1'b1, 1'b0);
        pulses(17, 6, 6);
        ticks(2);
        expect3("trip17", 16'd1, 8'd1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect3("mid_reset", 16'd0, 8'd0, 1'b0);
        rst = 1'b1;
        cycles(2);
        edges(1'b1, 1'b0);
        pulses(3, 6, 6);
        check("after_rst3 dist", 32'(distence), 32'd0);
        pulses(7, 6, 6);
        check("after_rst10 dist", 32'(distence), 32'd1);

        // Pulse accepted in the same cycle as the stop edge.
        do_reset();
        edges(1'b1, 1'b0);
        pulses(9, 6, 6);
        @(negedge clk);
        wheel = 1'b1;
        cycles(LAT - 1);
        stop = 1'b1;
        cycles(6);
        wheel = 1'b0;
        stop = 1'b0;
        cycles(12);
        expect3("stop_pulse", 16'd1, 8'd0, 1'b0);

        // Distance saturation from a preloaded value.
        do_reset();
        edges(1'b1, 1'b0);
        @(negedge clk);
        force dut.distence = 16'hFFFE;
        @(negedge clk);
        release dut.distence;
        @(negedge clk);
        pulses(20, 6, 6);
        check("sat20 dist", 32'(distence), 32'hFFFF);
        pulses(10, 6, 6);
        check("sat30 dist", 32'(distence), 32'hFFFF);
        check("sat run", 32'(running), 32'd1);

        // Wheel filtering behaviour.
        do_reset();
        edges(1'b1, 1'b0);
`ifdef MILEAGE_DEBOUNCE_EN
        pulses(15, 2, 4);
        check("glitch dist", 32'(distence), 32'd0);
        pulses(9, 6, 6);
        check("filt9 dist", 32'(distence), 32'd0);
        pulses(1, 6, 6);
        check("filt10 dist", 32'(distence), 32'd1);
`else
        pulses(15, 2, 2);
        check("narrow15 dist", 32'(distence), 32'd1);
        pulses(5, 1, 2);
        check("narrow20 dist", 32'(distence), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
